// File: rtl/axi_plugin_mstr_arb.sv
// Round-robin sharing of one AXI4 master port between N_REQ req/gnt/rvalid requesters.
// Each grant becomes a single-beat read or write; only one transaction is ever outstanding.
module axi_plugin_mstr_arb #(
  parameter int AXI4_ADDRESS_WIDTH = 32,
  parameter int AXI4_DATA_WIDTH    = 32,
  parameter int AXI4_ID_WIDTH      = 16,
  parameter int AXI4_USER_WIDTH    = 10,
  parameter int AXI_STRB_WIDTH     = AXI4_DATA_WIDTH/8,
  parameter int N_REQ              = 2
) (
  input  logic                                        ACLK,
  input  logic                                        ARESETn,
  input  logic [N_REQ-1:0]                            req_i,
  input  logic [N_REQ-1:0]                            we_i,
  input  logic [N_REQ-1:0][AXI4_ADDRESS_WIDTH-1:0]    addr_i,
  input  logic [N_REQ-1:0][AXI4_DATA_WIDTH-1:0]       wdata_i,
  input  logic [N_REQ-1:0][AXI_STRB_WIDTH-1:0]        be_i,
  output logic [N_REQ-1:0]                            gnt_o,
  output logic [N_REQ-1:0]                            rvalid_o,
  output logic [AXI4_DATA_WIDTH-1:0]                  rdata_o,
  output logic                                        err_o,
  output logic [AXI4_ID_WIDTH-1:0]                    AWID_o,
  output logic [AXI4_ADDRESS_WIDTH-1:0]               AWADDR_o,
  output logic [7:0]                                  AWLEN_o,
  output logic [2:0]                                  AWSIZE_o,
  output logic [1:0]                                  AWBURST_o,
  output logic                                        AWLOCK_o,
  output logic [3:0]                                  AWCACHE_o,
  output logic [2:0]                                  AWPROT_o,
  output logic [3:0]                                  AWREGION_o,
  output logic [AXI4_USER_WIDTH-1:0]                  AWUSER_o,
  output logic [3:0]                                  AWQOS_o,
  output logic                                        AWVALID_o,
  input  logic                                        AWREADY_i,
  output logic [AXI4_DATA_WIDTH-1:0]                  WDATA_o,
  output logic [AXI_STRB_WIDTH-1:0]                   WSTRB_o,
  output logic                                        WLAST_o,
  output logic [AXI4_USER_WIDTH-1:0]                  WUSER_o,
  output logic                                        WVALID_o,
  input  logic                                        WREADY_i,
  input  logic [AXI4_ID_WIDTH-1:0]                    BID_i,
  input  logic [1:0]                                  BRESP_i,
  input  logic [AXI4_USER_WIDTH-1:0]                  BUSER_i,
  input  logic                                        BVALID_i,
  output logic                                        BREADY_o,
  output logic [AXI4_ID_WIDTH-1:0]                    ARID_o,
  output logic [AXI4_ADDRESS_WIDTH-1:0]               ARADDR_o,
  output logic [7:0]                                  ARLEN_o,
  output logic [2:0]                                  ARSIZE_o,
  output logic [1:0]                                  ARBURST_o,
  output logic                                        ARLOCK_o,
  output logic [3:0]                                  ARCACHE_o,
  output logic [2:0]                                  ARPROT_o,
  output logic [3:0]                                  ARREGION_o,
  output logic [AXI4_USER_WIDTH-1:0]                  ARUSER_o,
  output logic [3:0]                                  ARQOS_o,
  output logic                                        ARVALID_o,
  input  logic                                        ARREADY_i,
  input  logic [AXI4_ID_WIDTH-1:0]                    RID_i,
  input  logic [AXI4_DATA_WIDTH-1:0]                  RDATA_i,
  input  logic [1:0]                                  RRESP_i,
  input  logic                                        RLAST_i,
  input  logic [AXI4_USER_WIDTH-1:0]                  RUSER_i,
  input  logic                                        RVALID_i,
  output logic                                        RREADY_o
);
  localparam int IDX_W = $clog2(N_REQ);
  localparam logic [2:0] BEAT_SIZE = 3'($clog2(AXI_STRB_WIDTH));

  typedef enum logic [2:0] {IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA} state_t;

  state_t                        state, state_next;
  logic [IDX_W-1:0]              rr_ptr, win, idx;
  logic                          any_req;
  logic [AXI4_ADDRESS_WIDTH-1:0] addr_q;
  logic [AXI4_DATA_WIDTH-1:0]    wdata_q;
  logic [AXI_STRB_WIDTH-1:0]     be_q;
  logic                          aw_valid, w_valid, ar_valid, b_ready, r_ready;
  logic                          aw_done, w_done;
  logic                          unused_in;

  // Scan from rr_ptr upward (wrapping); the descending loop leaves the nearest requester in win.
  always_comb begin
    int s;
    s       = 0;
    win     = rr_ptr;
    any_req = 1'b0;
    for (int i = N_REQ-1; i >= 0; i--) begin
      s = int'(rr_ptr) + i;
      if (s >= N_REQ) s = s - N_REQ;
      if (req_i[IDX_W'(s)]) begin
        win     = IDX_W'(s);
        any_req = 1'b1;
      end
    end
  end

  always_comb begin
    gnt_o = '0;
    if (state == IDLE && any_req && ARESETn) gnt_o[win] = 1'b1;
  end

  assign aw_done = !aw_valid || AWREADY_i;
  assign w_done  = !w_valid  || WREADY_i;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:         if (any_req) state_next = we_i[win] ? WR_ADDR_DATA : RD_ADDR;
      WR_ADDR_DATA: if (aw_done && w_done) state_next = WR_RESP;
      WR_RESP:      if (BVALID_i) state_next = IDLE;
      RD_ADDR:      if (ARREADY_i) state_next = RD_DATA;
      RD_DATA:      if (RVALID_i) state_next = IDLE;
      default:      state_next = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) state <= IDLE;
    else          state <= state_next;
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      rr_ptr   <= '0;
      idx      <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      aw_valid <= 1'b0;
      w_valid  <= 1'b0;
      ar_valid <= 1'b0;
      b_ready  <= 1'b0;
      r_ready  <= 1'b0;
      rvalid_o <= '0;
      rdata_o  <= '0;
      err_o    <= 1'b0;
    end else begin
      if (state == IDLE) begin
        aw_valid <= any_req && we_i[win];
        w_valid  <= any_req && we_i[win];
      end else begin
        aw_valid <= (state == WR_ADDR_DATA) && aw_valid && !AWREADY_i;
        w_valid  <= (state == WR_ADDR_DATA) && w_valid  && !WREADY_i;
      end
      ar_valid <= (state_next == RD_ADDR);
      b_ready  <= (state_next == WR_RESP);
      r_ready  <= (state_next == RD_DATA);
      rvalid_o <= '0;
      if (state == IDLE && any_req) begin
        idx     <= win;
        addr_q  <= addr_i[win];
        wdata_q <= wdata_i[win];
        be_q    <= be_i[win];
        rr_ptr  <= (int'(win) == N_REQ-1) ? '0 : win + 1'b1;
      end
      // Bit 1 of the response separates SLVERR/DECERR from OKAY/EXOKAY.
      if (state == WR_RESP && BVALID_i) begin
        rvalid_o[idx] <= 1'b1;
        err_o         <= BRESP_i[1];
        rdata_o       <= '0;
      end
      if (state == RD_DATA && RVALID_i) begin
        rvalid_o[idx] <= 1'b1;
        err_o         <= RRESP_i[1];
        rdata_o       <= RDATA_i;
      end
    end
  end

  assign AWID_o     = AXI4_ID_WIDTH'(idx);
  assign AWADDR_o   = addr_q;
  assign AWLEN_o    = 8'd0;
  assign AWSIZE_o   = BEAT_SIZE;
  assign AWBURST_o  = 2'b01;
  assign AWLOCK_o   = 1'b0;
  assign AWCACHE_o  = 4'd0;
  assign AWPROT_o   = 3'd0;
  assign AWREGION_o = 4'd0;
  assign AWUSER_o   = '0;
  assign AWQOS_o    = 4'd0;
  assign AWVALID_o  = aw_valid;
  assign WDATA_o    = wdata_q;
  assign WSTRB_o    = be_q;
  assign WLAST_o    = 1'b1;
  assign WUSER_o    = '0;
  assign WVALID_o   = w_valid;
  assign BREADY_o   = b_ready;
  assign ARID_o     = AXI4_ID_WIDTH'(idx);
  assign ARADDR_o   = addr_q;
  assign ARLEN_o    = 8'd0;
  assign ARSIZE_o   = BEAT_SIZE;
  assign ARBURST_o  = 2'b01;
  assign ARLOCK_o   = 1'b0;
  assign ARCACHE_o  = 4'd0;
  assign ARPROT_o   = 3'd0;
  assign ARREGION_o = 4'd0;
  assign ARUSER_o   = '0;
  assign ARQOS_o    = 4'd0;
  assign ARVALID_o  = ar_valid;
  assign RREADY_o   = r_ready;

  // IDs, user sideband and RLAST are intentionally ignored on the return path.
  assign unused_in = ^{BID_i, BUSER_i, BRESP_i[0], RID_i, RLAST_i, RUSER_i, RRESP_i[0]};
endmodule
